// File: rtl/l2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// l2_arbiter : arbitrates I-cache, D-cache and PTW requests onto a registered
//              L2 request slot, and routes L2 answers back by answer type.
//              Define L2ARB_FIXED_PRIO_EN for fixed priority PTW > D > I.
// Revision   : 1.0
// ============================================================================
module l2_arbiter #(
  parameter int PADDR_LEN   = 56,
  parameter int LINE_LEN    = 512,
  parameter int DW_LEN      = 64,
  parameter int WBB_TAG_LEN = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   ic_req_valid_i,
  output logic                   ic_req_ready_o,
  input  logic [PADDR_LEN-1:0]   ic_req_paddr_i,
  input  logic                   dc_req_valid_i,
  output logic                   dc_req_ready_o,
  input  logic                   dc_req_write_i,
  input  logic [PADDR_LEN-1:0]   dc_req_paddr_i,
  input  logic [LINE_LEN-1:0]    dc_req_line_i,
  input  logic [WBB_TAG_LEN-1:0] dc_req_wbb_tag_i,
  input  logic                   ptw_req_valid_i,
  output logic                   ptw_req_ready_o,
  input  logic [PADDR_LEN-1:0]   ptw_req_paddr_i,
  output logic                   l2_req_valid_o,
  input  logic                   l2_req_ready_i,
  output logic [1:0]             l2_req_type_o,
  output logic [PADDR_LEN-1:0]   l2_req_paddr_o,
  output logic [LINE_LEN-1:0]    l2_req_line_o,
  output logic [WBB_TAG_LEN-1:0] l2_req_wbb_tag_o,
  input  logic                   l2_ans_valid_i,
  output logic                   l2_ans_ready_o,
  input  logic [2:0]             l2_ans_type_i,
  input  logic [PADDR_LEN-1:0]   l2_ans_paddr_i,
  input  logic [LINE_LEN-1:0]    l2_ans_line_i,
  input  logic [DW_LEN-1:0]      l2_ans_data_i,
  input  logic [WBB_TAG_LEN-1:0] l2_ans_wbb_tag_i,
  output logic                   ic_ans_valid_o,
  input  logic                   ic_ans_ready_i,
  output logic                   dc_ans_valid_o,
  input  logic                   dc_ans_ready_i,
  output logic                   dc_ans_type_o,
  output logic                   dc_ans_wakeup_o,
  output logic                   ptw_ans_valid_o,
  input  logic                   ptw_ans_ready_i,
  output logic [PADDR_LEN-1:0]   ans_paddr_o,
  output logic [LINE_LEN-1:0]    ans_line_o,
  output logic [DW_LEN-1:0]      ans_data_o,
  output logic [WBB_TAG_LEN-1:0] ans_wbb_tag_o
);

  localparam logic [1:0] c_CLI_I = 2'd0;
  localparam logic [1:0] c_CLI_D = 2'd1;
  localparam logic [1:0] c_CLI_P = 2'd2;

  localparam logic [1:0] c_REQ_IREAD  = 2'd0;
  localparam logic [1:0] c_REQ_DREAD  = 2'd1;
  localparam logic [1:0] c_REQ_DWRITE = 2'd2;
  localparam logic [1:0] c_REQ_PTW    = 2'd3;

  localparam logic [2:0] c_ANS_PTW      = 3'd0;
  localparam logic [2:0] c_ANS_ILINE    = 3'd1;
  localparam logic [2:0] c_ANS_DREAD    = 3'd2;
  localparam logic [2:0] c_ANS_DWRITTEN = 3'd3;
  localparam logic [2:0] c_ANS_DWAKEUP  = 3'd4;

  // Client vectors are indexed [0]=I-cache, [1]=D-cache, [2]=PTW
  logic [2:0]             w_req_vld;
  logic [2:0]             w_gnt;
  logic [2:0]             w_hs;
  logic                   w_slot_load_ok;
  logic [1:0]             w_nxt_type;
  logic [PADDR_LEN-1:0]   w_nxt_paddr;
  logic [LINE_LEN-1:0]    w_nxt_line;
  logic [WBB_TAG_LEN-1:0] w_nxt_tag;

  logic                   r_slot_valid;
  logic [1:0]             r_slot_type;
  logic [PADDR_LEN-1:0]   r_slot_paddr;
  logic [LINE_LEN-1:0]    r_slot_line;
  logic [WBB_TAG_LEN-1:0] r_slot_tag;

  assign w_req_vld      = {ptw_req_valid_i, dc_req_valid_i, ic_req_valid_i};
  assign w_slot_load_ok = rst_ni && !flush_i && (!r_slot_valid || l2_req_ready_i);

  // Grants form a priority prefix: each client's grant depends only on the
  // valids of clients ranked above it, never on its own valid.
`ifdef L2ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt    = '0;
    w_gnt[2] = 1'b1;
    w_gnt[1] = !w_req_vld[2];
    w_gnt[0] = !w_req_vld[2] && !w_req_vld[1];
  end
`else
  logic [1:0] r_last_gnt;

  always_comb begin
    w_gnt = '0;
    unique case (r_last_gnt)
      c_CLI_I: begin
        w_gnt[1] = 1'b1;
        w_gnt[2] = !w_req_vld[1];
        w_gnt[0] = !w_req_vld[1] && !w_req_vld[2];
      end
      c_CLI_D: begin
        w_gnt[2] = 1'b1;
        w_gnt[0] = !w_req_vld[2];
        w_gnt[1] = !w_req_vld[2] && !w_req_vld[0];
      end
      default: begin
        w_gnt[0] = 1'b1;
        w_gnt[1] = !w_req_vld[0];
        w_gnt[2] = !w_req_vld[0] && !w_req_vld[1];
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       r_last_gnt <= c_CLI_P;
    else if (w_hs[0])  r_last_gnt <= c_CLI_I;
    else if (w_hs[1])  r_last_gnt <= c_CLI_D;
    else if (w_hs[2])  r_last_gnt <= c_CLI_P;
  end
`endif

  assign ic_req_ready_o  = w_gnt[0] && w_slot_load_ok;
  assign dc_req_ready_o  = w_gnt[1] && w_slot_load_ok;
  assign ptw_req_ready_o = w_gnt[2] && w_slot_load_ok;
  assign w_hs            = w_req_vld & w_gnt & {3{w_slot_load_ok}};

  always_comb begin
    w_nxt_type  = c_REQ_IREAD;
    w_nxt_paddr = ic_req_paddr_i;
    w_nxt_line  = '0;
    w_nxt_tag   = '0;
    if (w_hs[1]) begin
      w_nxt_type  = dc_req_write_i ? c_REQ_DWRITE : c_REQ_DREAD;
      w_nxt_paddr = dc_req_paddr_i;
      w_nxt_line  = dc_req_line_i;
      w_nxt_tag   = dc_req_wbb_tag_i;
    end else if (w_hs[2]) begin
      w_nxt_type  = c_REQ_PTW;
      w_nxt_paddr = ptw_req_paddr_i;
    end
  end

  // A new grant replaces the slot in the same cycle the L2 drains it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_valid <= 1'b0;
      r_slot_type  <= '0;
      r_slot_paddr <= '0;
      r_slot_line  <= '0;
      r_slot_tag   <= '0;
    end else if (flush_i) begin
      r_slot_valid <= 1'b0;
    end else if (|w_hs) begin
      r_slot_valid <= 1'b1;
      r_slot_type  <= w_nxt_type;
      r_slot_paddr <= w_nxt_paddr;
      r_slot_line  <= w_nxt_line;
      r_slot_tag   <= w_nxt_tag;
    end else if (l2_req_ready_i) begin
      r_slot_valid <= 1'b0;
    end
  end

  assign l2_req_valid_o   = r_slot_valid;
  assign l2_req_type_o    = r_slot_type;
  assign l2_req_paddr_o   = r_slot_paddr;
  assign l2_req_line_o    = r_slot_line;
  assign l2_req_wbb_tag_o = r_slot_tag;

  logic w_ans_ic;
  logic w_ans_dc;
  logic w_ans_ptw;
  logic w_ans_illegal;
  logic r_illegal_ans;

  always_comb begin
    w_ans_ic      = 1'b0;
    w_ans_dc      = 1'b0;
    w_ans_ptw     = 1'b0;
    w_ans_illegal = 1'b0;
    case (l2_ans_type_i)
      c_ANS_PTW:                                   w_ans_ptw     = 1'b1;
      c_ANS_ILINE:                                 w_ans_ic      = 1'b1;
      c_ANS_DREAD, c_ANS_DWRITTEN, c_ANS_DWAKEUP: w_ans_dc      = 1'b1;
      default:                                     w_ans_illegal = 1'b1;
    endcase
  end

  assign ic_ans_valid_o  = rst_ni && l2_ans_valid_i && w_ans_ic;
  assign dc_ans_valid_o  = rst_ni && l2_ans_valid_i && w_ans_dc;
  assign ptw_ans_valid_o = rst_ni && l2_ans_valid_i && w_ans_ptw;
  assign dc_ans_type_o   = w_ans_dc && (l2_ans_type_i != c_ANS_DREAD);
  assign dc_ans_wakeup_o = w_ans_dc && (l2_ans_type_i == c_ANS_DWAKEUP);

  // Illegal answer types are consumed and dropped so the L2 cannot lock up
  assign l2_ans_ready_o = rst_ni && ((w_ans_ic  && ic_ans_ready_i)  ||
                                     (w_ans_dc  && dc_ans_ready_i)  ||
                                     (w_ans_ptw && ptw_ans_ready_i) ||
                                     w_ans_illegal);

  assign ans_paddr_o   = l2_ans_paddr_i;
  assign ans_line_o    = l2_ans_line_i;
  assign ans_data_o    = l2_ans_data_i;
  assign ans_wbb_tag_o = l2_ans_wbb_tag_i;

  // Sticky record that an illegal answer type was ever seen
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              r_illegal_ans <= 1'b0;
    else if (l2_ans_valid_i && w_ans_illegal) r_illegal_ans <= 1'b1;
  end

  illegal_ans_seen: cover property (@(posedge clk_i) r_illegal_ans);

endmodule
`default_nettype wire

// File: tb/tb_l2_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_l2_arbiter : directed stimulus with request/answer scoreboards.
// Revision      : 1.0
// ============================================================================
module tb_l2_arbiter;
  localparam int PL = 56;
  localparam int LL = 512;
  localparam int DL = 64;
  localparam int TL = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          flush_i = 1'b0;
  logic          ic_req_valid_i = 1'b0, ic_req_ready_o;
  logic [PL-1:0] ic_req_paddr_i = '0;
  logic          dc_req_valid_i = 1'b0, dc_req_ready_o, dc_req_write_i = 1'b0;
  logic [PL-1:0] dc_req_paddr_i = '0;
  logic [LL-1:0] dc_req_line_i = '0;
  logic [TL-1:0] dc_req_wbb_tag_i = '0;
  logic          ptw_req_valid_i = 1'b0, ptw_req_ready_o;
  logic [PL-1:0] ptw_req_paddr_i = '0;
  logic          l2_req_valid_o, l2_req_ready_i = 1'b0;
  logic [1:0]    l2_req_type_o;
  logic [PL-1:0] l2_req_paddr_o;
  logic [LL-1:0] l2_req_line_o;
  logic [TL-1:0] l2_req_wbb_tag_o;
  logic          l2_ans_valid_i = 1'b0, l2_ans_ready_o;
  logic [2:0]    l2_ans_type_i = '0;
  logic [PL-1:0] l2_ans_paddr_i = '0;
  logic [LL-1:0] l2_ans_line_i = '0;
  logic [DL-1:0] l2_ans_data_i = '0;
  logic [TL-1:0] l2_ans_wbb_tag_i = '0;
  logic          ic_ans_valid_o, ic_ans_ready_i = 1'b0;
  logic          dc_ans_valid_o, dc_ans_ready_i = 1'b0, dc_ans_type_o, dc_ans_wakeup_o;
  logic          ptw_ans_valid_o, ptw_ans_ready_i = 1'b0;
  logic [PL-1:0] ans_paddr_o;
  logic [LL-1:0] ans_line_o;
  logic [DL-1:0] ans_data_o;
  logic [TL-1:0] ans_wbb_tag_o;

  l2_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_ready_o(ic_req_ready_o), .ic_req_paddr_i(ic_req_paddr_i),
    .dc_req_valid_i(dc_req_valid_i), .dc_req_ready_o(dc_req_ready_o), .dc_req_write_i(dc_req_write_i),
    .dc_req_paddr_i(dc_req_paddr_i), .dc_req_line_i(dc_req_line_i), .dc_req_wbb_tag_i(dc_req_wbb_tag_i),
    .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o), .ptw_req_paddr_i(ptw_req_paddr_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i), .l2_req_type_o(l2_req_type_o),
    .l2_req_paddr_o(l2_req_paddr_o), .l2_req_line_o(l2_req_line_o), .l2_req_wbb_tag_o(l2_req_wbb_tag_o),
    .l2_ans_valid_i(l2_ans_valid_i), .l2_ans_ready_o(l2_ans_ready_o), .l2_ans_type_i(l2_ans_type_i),
    .l2_ans_paddr_i(l2_ans_paddr_i), .l2_ans_line_i(l2_ans_line_i), .l2_ans_data_i(l2_ans_data_i),
    .l2_ans_wbb_tag_i(l2_ans_wbb_tag_i),
    .ic_ans_valid_o(ic_ans_valid_o), .ic_ans_ready_i(ic_ans_ready_i),
    .dc_ans_valid_o(dc_ans_valid_o), .dc_ans_ready_i(dc_ans_ready_i),
    .dc_ans_type_o(dc_ans_type_o), .dc_ans_wakeup_o(dc_ans_wakeup_o),
    .ptw_ans_valid_o(ptw_ans_valid_o), .ptw_ans_ready_i(ptw_ans_ready_i),
    .ans_paddr_o(ans_paddr_o), .ans_line_o(ans_line_o), .ans_data_o(ans_data_o),
    .ans_wbb_tag_o(ans_wbb_tag_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]    typ;
    logic [PL-1:0] paddr;
    logic [LL-1:0] line;
    logic [TL-1:0] tag;
  } req_t;

  typedef struct packed {
    logic          ic;
    logic          dc;
    logic          ptw;
    logic          dtype;
    logic          wake;
    logic [DL-1:0] data;
    logic [TL-1:0] tag;
  } ans_t;

  req_t req_q[$];
  ans_t ans_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    #1;
  endtask

  task automatic push_req(input logic [1:0] t, input logic [PL-1:0] p,
                          input logic [LL-1:0] l, input logic [TL-1:0] g);
    req_t r;
    r.typ = t; r.paddr = p; r.line = l; r.tag = g;
    req_q.push_back(r);
  endtask

  task automatic push_ans(input logic ic, input logic dc, input logic ptw, input logic dt,
                          input logic wk, input logic [DL-1:0] d, input logic [TL-1:0] g);
    ans_t a;
    a.ic = ic; a.dc = dc; a.ptw = ptw; a.dtype = dt; a.wake = wk; a.data = d; a.tag = g;
    ans_q.push_back(a);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    {ic_req_valid_i, dc_req_valid_i, ptw_req_valid_i, l2_req_ready_i, flush_i} = '0;
    {l2_ans_valid_i, ic_ans_ready_i, dc_ans_ready_i, ptw_ans_ready_i} = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  // Request monitor: one expected entry per accepted L2 request
  always @(negedge clk_i) begin
    req_t got;
    req_t exp;
    if (rst_ni && l2_req_valid_o && l2_req_ready_i) begin
      got = {l2_req_type_o, l2_req_paddr_o, l2_req_line_o, l2_req_wbb_tag_o};
      checks++;
      if (req_q.size() == 0) begin
        errors++;
        $display("FAIL l2_req unexpected: type=%0d paddr=%0h", got.typ, got.paddr);
      end else begin
        exp = req_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL l2_req: got type=%0d paddr=%0h tag=%0h line_ok=%0d expected type=%0d paddr=%0h tag=%0h",
                   got.typ, got.paddr, got.tag, (got.line === exp.line), exp.typ, exp.paddr, exp.tag);
        end
      end
    end
  end

  // Answer monitor: one expected entry per answer the arbiter consumes
  always @(negedge clk_i) begin
    ans_t got;
    ans_t exp;
    if (rst_ni && l2_ans_valid_i && l2_ans_ready_o) begin
      got = {ic_ans_valid_o, dc_ans_valid_o, ptw_ans_valid_o, dc_ans_type_o, dc_ans_wakeup_o,
             ans_data_o, ans_wbb_tag_o};
      checks++;
      if (ans_q.size() == 0) begin
        errors++;
        $display("FAIL l2_ans unexpected: vld(ic,dc,ptw)=%b%b%b", got.ic, got.dc, got.ptw);
      end else begin
        exp = ans_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL l2_ans: got vld=%b%b%b dt=%b wk=%b data=%0h tag=%0h expected vld=%b%b%b dt=%b wk=%b data=%0h tag=%0h",
                   got.ic, got.dc, got.ptw, got.dtype, got.wake, got.data, got.tag,
                   exp.ic, exp.dc, exp.ptw, exp.dtype, exp.wake, exp.data, exp.tag);
        end
      end
    end
  end

  initial begin
    logic [LL-1:0] wline;
    wline = {16{32'hCAFE_0001}};

    // Outputs while held in reset
    #2;
    chk("reset_outputs",
        {l2_req_valid_o, ic_req_ready_o, dc_req_ready_o, ptw_req_ready_o,
         l2_ans_ready_o, ic_ans_valid_o, dc_ans_valid_o, ptw_ans_valid_o}, 8'h00);
    chk("reset_slot_paddr", l2_req_paddr_o, 64'h0);
    do_reset();

    // Single I-cache request, one-cycle latency
    l2_req_ready_i = 1'b1;
    ic_req_valid_i = 1'b1;
    ic_req_paddr_i = 56'h1000;
    push_req(2'd0, 56'h1000, '0, '0);
    at_neg();
    chk("ic_ready_first", ic_req_ready_o, 1);
    tick();
    ic_req_valid_i = 1'b0;
    at_neg();
    chk("ic_slot_valid", l2_req_valid_o, 1);
    tick();
    at_neg();
    chk("ic_slot_empty", l2_req_valid_o, 0);

    // All three clients contending every cycle
    do_reset();
    l2_req_ready_i  = 1'b1;
    ic_req_paddr_i  = 56'h100;
    dc_req_paddr_i  = 56'h200;
    dc_req_write_i  = 1'b0;
    dc_req_line_i   = '0;
    dc_req_wbb_tag_i = '0;
    ptw_req_paddr_i = 56'h300;
    for (int i = 0; i < 2; i++) begin
`ifdef L2ARB_FIXED_PRIO_EN
      for (int k = 0; k < 3; k++) push_req(2'd3, 56'h300, '0, '0);
`else
      push_req(2'd0, 56'h100, '0, '0);
      push_req(2'd1, 56'h200, '0, '0);
      push_req(2'd3, 56'h300, '0, '0);
`endif
    end
    {ic_req_valid_i, dc_req_valid_i, ptw_req_valid_i} = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) {ic_req_valid_i, dc_req_valid_i, ptw_req_valid_i} = 3'b000;
      at_neg();
      chk("rr_throughput", l2_req_valid_o, 1);
    end
    tick();
    at_neg();
    chk("rr_drained", l2_req_valid_o, 0);
    chk("rr_queue_empty", req_q.size(), 0);

    // D-cache write stalled by L2 for 4 cycles; I-cache waits then loads with no bubble
    do_reset();
    l2_req_ready_i   = 1'b0;
    dc_req_valid_i   = 1'b1;
    dc_req_write_i   = 1'b1;
    dc_req_paddr_i   = 56'h2040;
    dc_req_line_i    = wline;
    dc_req_wbb_tag_i = 4'd5;
    push_req(2'd2, 56'h2040, wline, 4'd5);
    push_req(2'd0, 56'h5000, '0, '0);
    tick();
    dc_req_valid_i = 1'b0;
    ic_req_valid_i = 1'b1;
    ic_req_paddr_i = 56'h5000;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("stall_readys", {ic_req_ready_o, dc_req_ready_o, ptw_req_ready_o}, 3'b000);
      chk("stall_hold", {l2_req_valid_o, l2_req_type_o, l2_req_wbb_tag_o, l2_req_paddr_o[15:0]},
          {1'b1, 2'd2, 4'd5, 16'h2040});
      tick();
    end
    l2_req_ready_i = 1'b1;
    at_neg();
    chk("stall_release_ready", ic_req_ready_o, 1);
    tick();
    ic_req_valid_i = 1'b0;
    at_neg();
    chk("no_bubble_valid", l2_req_valid_o, 1);
    tick();
    at_neg();
    chk("stall_drained", l2_req_valid_o, 0);

    // WakeUp answer with D-cache back-pressure
    l2_ans_valid_i   = 1'b1;
    l2_ans_type_i    = 3'd4;
    l2_ans_wbb_tag_i = 4'd3;
    l2_ans_data_i    = 64'h11;
    dc_ans_ready_i   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("wake_route", {dc_ans_valid_o, dc_ans_wakeup_o, dc_ans_type_o, l2_ans_ready_o,
                         ic_ans_valid_o, ptw_ans_valid_o}, 6'b111000);
      tick();
    end
    dc_ans_ready_i = 1'b1;
    push_ans(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h11, 4'd3);
    at_neg();
    chk("wake_ready", l2_ans_ready_o, 1);
    tick();

    // DC line read answer
    l2_ans_type_i = 3'd2;
    l2_ans_data_i = 64'h22;
    push_ans(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h22, 4'd3);
    at_neg();
    chk("dread_type", dc_ans_type_o, 0);
    tick();

    // PTW answer, then an illegal type
    l2_ans_type_i    = 3'd0;
    l2_ans_data_i    = 64'hDEADBEEF;
    l2_ans_wbb_tag_i = 4'd0;
    ptw_ans_ready_i  = 1'b1;
    push_ans(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hDEADBEEF, 4'd0);
    at_neg();
    chk("ptw_ans", {ptw_ans_valid_o, ans_data_o}, {1'b1, 64'hDEADBEEF});
    chk("illegal_flag_clear", dut.r_illegal_ans, 0);
    tick();
    l2_ans_type_i = 3'd6;
    push_ans(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'hDEADBEEF, 4'd0);
    at_neg();
    chk("illegal_drop", {l2_ans_ready_o, ic_ans_valid_o, dc_ans_valid_o, ptw_ans_valid_o}, 4'b1000);
    tick();
    l2_ans_valid_i = 1'b0;
    at_neg();
    chk("illegal_flag_sticky", dut.r_illegal_ans, 1);

    // Flush of a stalled PTW request, then reset mid-stall
    do_reset();
    l2_req_ready_i  = 1'b0;
    ptw_req_valid_i = 1'b1;
    ptw_req_paddr_i = 56'h3000;
    tick();
    ptw_req_valid_i = 1'b0;
    at_neg();
    chk("flush_slot_full", {l2_req_valid_o, l2_req_type_o}, {1'b1, 2'd3});
    flush_i         = 1'b1;
    l2_req_ready_i  = 1'b1;
    ptw_req_valid_i = 1'b1;
    #1;
    chk("flush_readys", {ic_req_ready_o, dc_req_ready_o, ptw_req_ready_o}, 3'b000);
    tick();
    flush_i         = 1'b0;
    ptw_req_valid_i = 1'b0;
    l2_req_ready_i  = 1'b0;
    at_neg();
    chk("flush_cleared", l2_req_valid_o, 0);

    ptw_req_valid_i  = 1'b1;
    ptw_req_paddr_i  = 56'h4000;
    l2_ans_valid_i   = 1'b1;
    l2_ans_type_i    = 3'd1;
    l2_ans_data_i    = 64'h33;
    l2_ans_wbb_tag_i = 4'd0;
    ic_ans_ready_i   = 1'b1;
    push_ans(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h33, 4'd0);
    tick();
    ptw_req_valid_i = 1'b0;
    at_neg();
    chk("pre_reset_state", {l2_req_valid_o, ic_ans_valid_o}, 2'b11);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("async_reset_outputs",
        {l2_req_valid_o, ic_req_ready_o, dc_req_ready_o, ptw_req_ready_o,
         l2_ans_ready_o, ic_ans_valid_o, dc_ans_valid_o, ptw_ans_valid_o}, 8'h00);
    l2_ans_valid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    at_neg();
    chk("reset_discard", l2_req_valid_o, 0);

    chk("req_queue_empty", req_q.size(), 0);
    chk("ans_queue_empty", ans_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Sits directly upstream of the L2 cache request channel and is the single consumer of its answer channel.
- Request side: arbitrates requests from three L1-side clients (I-cache, D-cache, PTW) onto one registered L2 request channel.
- Answer side: routes each L2 answer back to the owning client by answer type.
- Flow control: valid/ready on every channel, both directions.

Parameters:
- PADDR_LEN, 56, physical address width.
- LINE_LEN, 512, cache line width in bits.
- DW_LEN, 64, doubleword width.
- WBB_TAG_LEN, 4, D-cache write-back-buffer tag width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush.
- ic_req_valid_i / ic_req_ready_o  in/out  1  I-cache line read request handshake.
- ic_req_paddr_i  in  PADDR_LEN  I-cache line address.
- dc_req_valid_i / dc_req_ready_o  in/out  1  D-cache request handshake.
- dc_req_write_i  in  1  0 = DReadLine, 1 = DWriteLine.
- dc_req_paddr_i  in  PADDR_LEN  D-cache address.
- dc_req_line_i  in  LINE_LEN  write data.
- dc_req_wbb_tag_i  in  WBB_TAG_LEN  WBB tag.
- ptw_req_valid_i / ptw_req_ready_o  in/out  1  PTW doubleword load request handshake.
- ptw_req_paddr_i  in  PADDR_LEN  PTW address.
- l2_req_valid_o / l2_req_ready_i  out/in  1  L2 request handshake.
- l2_req_type_o  out  2  0 = IReadLine, 1 = DReadLine, 2 = DWriteLine, 3 = PTWLoad.
- l2_req_paddr_o  out  PADDR_LEN  request address.
- l2_req_line_o  out  LINE_LEN  write line data.
- l2_req_wbb_tag_o  out  WBB_TAG_LEN  WBB tag.
- l2_ans_valid_i / l2_ans_ready_o  in/out  1  L2 answer handshake.
- l2_ans_type_i  in  3  0 = PTWLoad, 1 = ILineRead, 2 = DLineRead, 3 = DLineWritten, 4 = DWbbWakeUp.
- l2_ans_paddr_i  in  PADDR_LEN  answer address.
- l2_ans_line_i  in  LINE_LEN  answer line.
- l2_ans_data_i  in  DW_LEN  answer doubleword.
- l2_ans_wbb_tag_i  in  WBB_TAG_LEN  answer WBB tag.
- ic_ans_valid_o / ic_ans_ready_i  out/in  1  I-cache answer handshake.
- dc_ans_valid_o / dc_ans_ready_i  out/in  1  D-cache answer handshake.
- dc_ans_type_o  out  1  0 = line read, 1 = line written; WakeUp is reported as written plus dc_ans_wakeup_o.
- dc_ans_wakeup_o  out  1  marks a DWbbWakeUp answer.
- ptw_ans_valid_o / ptw_ans_ready_i  out/in  1  PTW answer handshake.
- ans_paddr_o  out  PADDR_LEN  shared answer payload, passthrough.
- ans_line_o  out  LINE_LEN  shared answer payload, passthrough.
- ans_data_o  out  DW_LEN  shared answer payload, passthrough.
- ans_wbb_tag_o  out  WBB_TAG_LEN  shared answer payload, passthrough.

Behaviour:
- Request path is a one-entry output register (slot).
  - Slot accepts a new request when it is empty, or when the L2 accepts in the same cycle (l2_req_valid_o && l2_req_ready_i).
  - Full throughput is 1 request/cycle.
  - Latency from client handshake to l2_req_valid_o is 1 cycle.
- Arbitration is round-robin over the order I, D, PTW, using a 2-bit last-grant pointer.
  - Highest priority goes to the client after the last granted one.
  - Pointer updates only on an actual client handshake.
  - Reset pointer = PTW, so I-cache wins the first conflict.
- Only the granted client sees ready=1, and only when the slot can load.
- Client ready is independent of the client's own valid (no combinational valid→ready loop on itself).
- Slot contents are held stable while l2_req_valid_o=1 && !l2_req_ready_i.
- Answer path is combinational with no buffering.
  - Destination decode: type 1 → IC; types 2, 3, 4 → DC; type 0 → PTW.
  - Selected client's *_ans_valid_o = l2_ans_valid_i.
  - l2_ans_ready_o = selected client's ready.
  - Non-selected valid outputs = 0.
  - Illegal type (5–7): l2_ans_ready_o = 1 (answer dropped), no client valid, and a sticky simulation assertion fires.
- Flush (flush_i=1): slot valid cleared next cycle, client readys forced 0 that cycle, pointer unchanged. The answer path is unaffected by flush.
- Reset (asynchronous, any time):
  - Slot valid = 0, payload = 0, pointer = PTW.
  - All *_valid_o and *_ready_o deassert immediately.
  - An in-flight slot request is discarded.
- Simultaneous L2 accept and new grant in one cycle: slot is replaced with no bubble.

Optional Feature:
- Macro: L2ARB_FIXED_PRIO_EN.
- Defined: fixed priority PTW > D > I; pointer logic removed.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then IC paddr 0x1000 valid with l2_req_ready_i=1 → next cycle l2_req_valid_o=1, type=0, paddr=0x1000; one cycle later valid=0.
- IC, DC and PTW valid every cycle, l2_req_ready_i=1 → grant order I, D, P, I, D, P; exactly 1 request/cycle; with FIXED_PRIO_EN only PTW is granted.
- DC write (paddr 0x2040, tag 5) granted, l2_req_ready_i=0 for 4 cycles → slot held stable, all client readys 0 for those cycles; handshake completes on cycle 5.
- Answer type 4, tag 3, dc_ans_ready_i=0 for 2 cycles → dc_ans_valid_o=1, dc_ans_wakeup_o=1, l2_ans_ready_o=0 for 2 cycles, then 1; ic_ans_valid_o and ptw_ans_valid_o remain 0.
- Answer type 0, data 0xDEADBEEF → ptw_ans_valid_o=1, ans_data_o=0xDEADBEEF; type 6 → l2_ans_ready_o=1, no client valid, assertion flagged.
- Slot full with PTW request, flush_i pulse → l2_req_valid_o=0 next cycle; assert rst_ni mid-stall → all valid/ready outputs 0 immediately.
